// File: rtl/rr_pkg.sv
// Shared helpers for the response return router: ID sizing, grant decode
// and sticky error flag bit positions.
package rr_pkg;

  localparam int unsigned MAX_REQS  = 32;
  localparam int unsigned ERR_OVF   = 0;
  localparam int unsigned ERR_MULTI = 1;

  // ID width for a given requester count; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // True when exactly one bit of the (zero-extended) grant vector is set.
  function automatic logic is_onehot(input logic [MAX_REQS-1:0] v);
    return (v != '0) && ((v & (v - MAX_REQS'(1))) == '0);
  endfunction

  // Binary index of the set bit; only meaningful for a one-hot input.
  function automatic logic [4:0] onehot_to_idx(input logic [MAX_REQS-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQS; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_rsp_return_router_id_fifo.sv
// In-order FIFO of requester IDs awaiting their response.
// Callers never push when full or pop when empty.
module id_fifo #(
  parameter int unsigned ID_W  = 3,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ID_W-1:0]            din,
  output logic [ID_W-1:0]            dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [ID_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Next-state: write at wr_ptr, advance pointers (wrap by power-of-two width).
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rr_rsp_return_router.sv
// Logs arbiter grants as requester IDs and steers the shared response
// stream back to the requester that won each grant, strictly in order.
module rr_rsp_return_router
  import rr_pkg::*;
#(
  parameter int unsigned NUM_REQS = 5,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQS-1:0]        grants,
  input  logic                       rsp_valid,
  input  logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_ready,
  output logic [NUM_REQS-1:0]        out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic [NUM_REQS-1:0]        out_ready,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic [1:0]                 err_status
);

  localparam int unsigned ID_W  = id_width(NUM_REQS);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [MAX_REQS-1:0] grants_ext;
  logic                grant_onehot;
  logic                grant_multi;
  logic                push;
  logic                accept;
  logic                stage_free;
  logic [ID_W-1:0]     push_id;
  logic [ID_W-1:0]     head_id;
  logic [CNT_W-1:0]    count;

  logic [NUM_REQS-1:0] out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q,  out_data_d;
  logic [1:0]          err_status_q, err_status_d;

  id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (accept),
    .din   (push_id),
    .dout  (head_id),
    .count (count)
  );

  // Grant decode, full check on registered count, and response handshake.
  always_comb begin
    grants_ext   = MAX_REQS'(grants);
    grant_onehot = is_onehot(grants_ext);
    grant_multi  = (grants != '0) && !grant_onehot;
    push_id      = ID_W'(onehot_to_idx(grants_ext));
    full         = (count == CNT_W'(DEPTH));
    push         = grant_onehot && !full;
    stage_free   = (out_valid_q == '0) || ((out_valid_q & out_ready) != '0);
    rsp_ready    = (count != '0) && stage_free;
    accept       = rsp_valid && rsp_ready;
    outstanding  = count;
  end

  // Output stage load/clear/hold and sticky error flags.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    err_status_d = err_status_q;
    if (accept) begin
      out_valid_d = NUM_REQS'(1) << head_id;
      out_data_d  = rsp_data;
    end else if (stage_free) begin
      out_valid_d = '0;
    end
    if (grant_onehot && full) err_status_d[ERR_OVF]   = 1'b1;
    if (grant_multi)          err_status_d[ERR_MULTI] = 1'b1;
  end

  // Output and error registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= '0;
      out_data_q   <= '0;
      err_status_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      err_status_q <= err_status_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign err_status = err_status_q;

endmodule

// File: tb/tb_rr_rsp_return_router.sv
// Self-checking bench: directed scenarios then random traffic, all checked
// against a queue-based reference model of the return router.
module tb_rr_rsp_return_router;

  localparam int NUM_REQS = 5;
  localparam int DATA_W   = 16;
  localparam int DEPTH    = 8;
  localparam int CNT_W    = $clog2(DEPTH+1);

  logic                clk = 1'b0;
  logic                reset;
  logic [NUM_REQS-1:0] grants;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_ready;
  logic [NUM_REQS-1:0] out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [NUM_REQS-1:0] out_ready;
  logic                full;
  logic [CNT_W-1:0]    outstanding;
  logic [1:0]          err_status;

  rr_rsp_return_router #(
    .NUM_REQS (NUM_REQS),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .grants      (grants),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_ready   (rsp_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .full        (full),
    .outstanding (outstanding),
    .err_status  (err_status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of pending requester indices, output slot
  // (-1 = empty), payload and sticky errors.
  int          m_q[$];
  int          m_ov;
  logic [15:0] m_od;
  logic [1:0]  m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready();
    return (m_q.size() != 0) && ((m_ov < 0) || out_ready[m_ov]);
  endfunction

  task automatic check_model(input string tag);
    logic [NUM_REQS-1:0] exp_ov;
    exp_ov = (m_ov < 0) ? '0 : NUM_REQS'(1) << m_ov;
    chk({tag, ".out_valid"},   32'(out_valid),   32'(exp_ov));
    chk({tag, ".out_data"},    32'(out_data),    32'(m_od));
    chk({tag, ".rsp_ready"},   32'(rsp_ready),   32'(model_ready()));
    chk({tag, ".outstanding"}, 32'(outstanding), 32'(m_q.size()));
    chk({tag, ".full"},        32'(full),        32'(m_q.size() == DEPTH));
    chk({tag, ".err_status"},  32'(err_status),  32'(m_err));
  endtask

  // Called at posedge+1 with new inputs applied; checks then advances one clock.
  task automatic cycle(input string tag);
    int          n_ov;
    logic [15:0] n_od;
    int          size_before;
    int          idx;
    #2;
    check_model(tag);
    n_ov = m_ov;
    n_od = m_od;
    size_before = m_q.size();
    if (rsp_valid && model_ready()) begin
      n_ov = m_q.pop_front();
      n_od = rsp_data;
    end else if (m_ov >= 0 && out_ready[m_ov]) begin
      n_ov = -1;
    end
    if ($countones(grants) == 1) begin
      idx = 0;
      for (int i = 0; i < NUM_REQS; i++) if (grants[i]) idx = i;
      if (size_before < DEPTH) m_q.push_back(idx);
      else m_err[0] = 1'b1;
    end else if ($countones(grants) > 1) begin
      m_err[1] = 1'b1;
    end
    @(posedge clk);
    #1;
    m_ov = n_ov;
    m_od = n_od;
  endtask

  task automatic model_clear();
    m_q.delete();
    m_ov  = -1;
    m_od  = '0;
    m_err = '0;
  endtask

  // Asynchronous reset: outputs must clear without any clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    model_clear();
    chk({tag, ".async_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, ".async_out_data"},  32'(out_data),  32'h0);
    chk({tag, ".async_outst"},     32'(outstanding), 32'h0);
    chk({tag, ".async_err"},       32'(err_status), 32'h0);
    chk({tag, ".async_full"},      32'(full), 32'h0);
    chk({tag, ".async_rsp_ready"}, 32'(rsp_ready), 32'h0);
    grants    = '0;
    rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [NUM_REQS-1:0] g;
    int r;
    reset     = 1'b1;
    grants    = '0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    out_ready = '1;
    model_clear();
    #2;
    do_reset("rst0");

    // Idle with responses offered: nothing accepted.
    grants = '0; rsp_valid = 1'b1; rsp_data = 16'hDEAD; out_ready = '1;
    repeat (5) cycle("idle");
    chk("idle.rsp_ready", 32'(rsp_ready), 32'h0);

    // Single round trip.
    rsp_valid = 1'b0;
    grants = 5'b00100; cycle("rt.grant");
    grants = '0;       cycle("rt.gap");
    chk("rt.outstanding", 32'(outstanding), 32'h1);
    rsp_valid = 1'b1; rsp_data = 16'hBEEF;
    #1 chk("rt.rsp_ready", 32'(rsp_ready), 32'h1);
    cycle("rt.rsp");
    rsp_valid = 1'b0;
    chk("rt.out_valid", 32'(out_valid), 32'h04);
    chk("rt.out_data",  32'(out_data),  32'hBEEF);
    cycle("rt.consume");
    chk("rt.cleared", 32'(out_valid), 32'h0);

    // Ordering.
    grants = 5'b00001; cycle("ord.g1");
    grants = 5'b10000; cycle("ord.g2");
    grants = 5'b00010; cycle("ord.g3");
    grants = '0;
    rsp_valid = 1'b1; rsp_data = 16'hA001; cycle("ord.r1");
    chk("ord.ov1", 32'(out_valid), 32'h01);
    rsp_data = 16'hA002; cycle("ord.r2");
    chk("ord.ov2", 32'(out_valid), 32'h10);
    rsp_data = 16'hA003; cycle("ord.r3");
    chk("ord.ov3", 32'(out_valid), 32'h02);
    chk("ord.od3", 32'(out_data),  32'hA003);
    rsp_valid = 1'b0; cycle("ord.drain");

    // Back-pressure on requester 3.
    grants = 5'b01000; cycle("bp.g1");
    grants = 5'b00010; cycle("bp.g2");
    grants = '0;
    out_ready = 5'b10111;
    rsp_valid = 1'b1; rsp_data = 16'h1234; cycle("bp.r1");
    rsp_data = 16'h5678;
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp.rsp_ready_blocked", 32'(rsp_ready), 32'h0);
      chk("bp.hold_valid", 32'(out_valid), 32'h08);
      chk("bp.hold_data",  32'(out_data),  32'h1234);
      cycle("bp.hold");
    end
    out_ready = '1; cycle("bp.release");
    chk("bp.next_valid", 32'(out_valid), 32'h02);
    chk("bp.next_data",  32'(out_data),  32'h5678);
    rsp_valid = 1'b0; cycle("bp.drain");

    // Fill to DEPTH, then overflow.
    for (int i = 0; i < DEPTH; i++) begin
      g = NUM_REQS'(1) << (i % NUM_REQS);
      grants = g; cycle("full.fill");
    end
    grants = '0;
    chk("full.flag", 32'(full), 32'h1);
    chk("full.outstanding", 32'(outstanding), 32'h8);
    grants = 5'b00001; cycle("full.ovf");
    grants = '0;
    chk("full.err", 32'(err_status), 32'h1);
    chk("full.outstanding_after", 32'(outstanding), 32'h8);
    rsp_valid = 1'b1; rsp_data = 16'h0F0F; cycle("full.pop");
    rsp_valid = 1'b0;
    chk("full.cleared", 32'(full), 32'h0);
    cycle("full.consume");

    // Non-one-hot grant.
    grants = 5'b00110; cycle("multi");
    grants = '0;
    chk("multi.err", 32'(err_status), 32'h3);
    chk("multi.outstanding", 32'(outstanding), 32'h7);

    // Reset mid-stream with a pending output.
    out_ready = '0; rsp_valid = 1'b1; rsp_data = 16'h7777; cycle("mid.load");
    rsp_valid = 1'b0;
    chk("mid.pending", 32'(out_valid != '0), 32'h1);
    do_reset("rst_mid");
    out_ready = '1;
    cycle("mid.after");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset("rst_rand");
      r = int'($urandom_range(0, 19));
      if (r < 7)       grants = '0;
      else if (r < 19) grants = NUM_REQS'(1) << $urandom_range(0, NUM_REQS-1);
      else             grants = NUM_REQS'(3) << $urandom_range(0, NUM_REQS-2);
      rsp_valid = ($urandom_range(0, 9) < 6);
      rsp_data  = DATA_W'($urandom);
      out_ready = NUM_REQS'($urandom) | NUM_REQS'($urandom);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_rsp_return_router.md
Name: rr_rsp_return_router

Overview:
- Return-path companion to the round-robin request arbiter.
- Logs each registered one-hot grant, as a requester index, into an in-order outstanding-ID FIFO.
- Steers the single shared downstream response stream back to the requester that won the matching grant.
- Sits between the shared resource's response port and the NUM_REQS requesters. Also drives a full flag that the arbiter wrapper uses to mask reqs.

Parameters:
- NUM_REQS, 5, number of requesters; must match the arbiter's num_reqs.
- DATA_W, 16, response payload width.
- DEPTH, 8, maximum outstanding grants; power of two, >=2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset; all state clears while low.
- grants  input  NUM_REQS  registered grant vector from the arbiter; all-zero means no grant this cycle.
- rsp_valid  input  1  downstream response valid.
- rsp_data  input  DATA_W  downstream response payload.
- rsp_ready  output  1  response accepted when rsp_valid && rsp_ready.
- out_valid  output  NUM_REQS  one-hot per-requester response valid; all-zero when idle.
- out_data  output  DATA_W  response payload, shared by all requesters.
- out_ready  input  NUM_REQS  per-requester ready.
- full  output  1  FIFO holds DEPTH IDs; arbiter wrapper must gate reqs.
- outstanding  output  $clog2(DEPTH+1)  current FIFO occupancy.
- err_status  output  2  sticky flags: [0] grant dropped while full, [1] non-one-hot grant.

Behaviour:
- Reset values while reset low: rd_ptr=0, wr_ptr=0, count=0, out_valid=0, out_data=0, err_status=0. Derived outputs then give full=0, outstanding=0, rsp_ready=0.
- Grant capture, evaluated each rising edge:
  - grants one-hot and count<DEPTH: push the binary index of the set bit; wr_ptr wraps modulo DEPTH.
  - grants one-hot and count==DEPTH: no push; set err_status[0].
  - grants has more than one bit set: no push; set err_status[1]; FIFO untouched.
  - grants==0: no action.
- Output stage: a single register holding out_valid (one-hot) and out_data.
  - Stage is free when out_valid==0, or when (out_valid & out_ready)!=0 in the same cycle.
- rsp_ready (combinational) = (count!=0) && stage free.
  - An empty FIFO never accepts a response.
  - A grant and a response in the same cycle with an empty FIFO: the grant is pushed; the response waits at least one cycle. There is no bypass.
- Response acceptance (rsp_valid && rsp_ready) at an edge:
  - out_valid <= 1<<fifo[rd_ptr]; out_data <= rsp_data.
  - Pop: rd_ptr wraps modulo DEPTH.
  - Latency: response accepted at edge N, out_valid visible after edge N.
- Consume without a new accept: out_valid <= 0; out_data holds its value.
- Back-pressure: while out_valid is set and the target's out_ready=0, out_valid and out_data hold stable and rsp_ready=0.
- Simultaneous push and pop: count is unchanged. A push at count==DEPTH with a same-cycle pop is still dropped, because the full check uses the registered count.
- Derived outputs: full = (count==DEPTH); outstanding = count.
- Responses are strictly in grant order; no reordering.
- Reset asserted mid-operation: all queued IDs and any pending output are discarded immediately. No output pulse on release.

Decomposition:
- Package rr_pkg:
  - localparam ID_W = $clog2(NUM_REQS) helper function.
  - onehot_to_idx function.
  - is_onehot function.
  - err_status bit-position constants ERR_OVF=0, ERR_MULTI=1.
- Sub-module id_fifo: synchronous FIFO of ID_W x DEPTH.
  - Ports: push, pop, din, dout, count.
  - Same clk and reset convention.
- Top level holds the grant decode, output register and error flags.

Test Plan:
- Reset then idle: grants=0, rsp_valid=1 for 5 cycles -> rsp_ready=0, out_valid=0, outstanding=0.
- Single round trip: grants=5'b00100 at cycle 1; rsp_valid=1 with data 16'hBEEF at cycle 3; out_ready=all 1s.
  - rsp_ready=1 at cycle 3.
  - out_valid=5'b00100, out_data=16'hBEEF at cycle 4, cleared at cycle 5.
- Ordering: grants 00001, 10000, 00010 on consecutive cycles; then responses A1, A2, A3 -> out_valid sequence 00001, 10000, 00010 carrying A1, A2, A3.
- Back-pressure: one grant to bit 3, response 16'h1234, out_ready[3]=0 for 4 cycles.
  - out_valid=5'b01000 held stable; a second queued response sees rsp_ready=0.
  - Delivered one cycle after out_ready[3] rises.
- Full/overflow: 8 grants with no responses -> full=1, outstanding=8.
  - 9th grant -> err_status=2'b01, outstanding stays 8.
  - After one response is consumed, full=0.
- Error and reset:
  - grants=5'b00110 -> err_status[1]=1, outstanding unchanged.
  - Reset asserted mid-stream with out_valid set -> all outputs return to reset values asynchronously.
